// File: rtl/vga_timing_monitor_if.sv
// Sync input and recovered-timing output bundle of the VGA timing monitor.
// master = video source side, slave = monitor side.
interface vga_timing_monitor_if;
    logic       hsync_in;
    logic       vsync_in;
    logic       locked;
    logic [9:0] hpos_rx;
    logic [9:0] vpos_rx;
    logic       de_rx;
    logic       frame_start;
    logic       h_err;
    logic       v_err;
    logic [7:0] err_count;

    modport master (
        output hsync_in, vsync_in,
        input  locked, hpos_rx, vpos_rx, de_rx, frame_start, h_err, v_err, err_count
    );

    modport slave (
        input  hsync_in, vsync_in,
        output locked, hpos_rx, vpos_rx, de_rx, frame_start, h_err, v_err, err_count
    );
endinterface

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing checker: measures incoming sync timing against a
// fixed mode, locks after consecutive good frames and recovers pixel position.
module vga_timing_monitor #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                clk,
    input  logic                reset,
    vga_timing_monitor_if.slave vif
);
    localparam int H_TOTAL      = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_ACTIVE + H_FRONT;
    localparam int V_SYNC_START = V_ACTIVE + V_FRONT;

    localparam logic [10:0] LINE_LEN_C  = 11'(H_TOTAL);
    localparam logic [10:0] LINE_TMO_C  = 11'(2 * H_TOTAL);
    localparam logic [10:0] HSYNC_LEN_C = 11'(H_SYNC);
    localparam logic [10:0] CNT11_MAX_C = 11'h7FF;
    localparam logic [9:0]  FRAME_LEN_C = 10'(V_TOTAL);
    localparam logic [9:0]  VSYNC_LEN_C = 10'(V_SYNC);
    localparam logic [9:0]  CNT10_MAX_C = 10'h3FF;
    localparam logic [9:0]  HPOS_LAST_C = 10'(H_TOTAL - 1);
    localparam logic [9:0]  VPOS_LAST_C = 10'(V_TOTAL - 1);
    localparam logic [9:0]  HPOS_SYNC_C = 10'(H_SYNC_START);
    localparam logic [9:0]  VPOS_SYNC_C = 10'(V_SYNC_START);
    localparam logic [9:0]  H_VIS_C     = 10'(H_ACTIVE);
    localparam logic [9:0]  V_VIS_C     = 10'(V_ACTIVE);
    localparam logic [3:0]  LOCK_C      = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;

    state_t      state_r, state_s;
    logic [3:0]  good_frames_r, good_frames_s;
    logic        hsync_d_r, vsync_d_r, h_seen_r, h_seen_s;
    logic [10:0] line_cnt_r, line_cnt_s, hwid_cnt_r, hwid_cnt_s;
    logic [9:0]  frame_lines_r, frame_lines_s, vwid_cnt_r, vwid_cnt_s;
    logic [9:0]  hpos_r, hpos_s, vpos_r, vpos_s;
    logic        locked_r, de_r, de_s, frame_start_r, frame_start_s;
    logic        h_err_r, h_err_s, v_err_r, v_err_s, err_any_s;
    logic [7:0]  err_count_r, err_count_s;
    logic        hrise_s, hfall_s, vrise_s, vfall_s, timeout_s, hwrap_s;

    // Measurement, error detection, lock FSM and position recovery next-state.
    always_comb begin
        hrise_s = vif.hsync_in & ~hsync_d_r;
        hfall_s = ~vif.hsync_in & hsync_d_r;
        vrise_s = vif.vsync_in & ~vsync_d_r;
        vfall_s = ~vif.vsync_in & vsync_d_r;

        if (hrise_s) begin
            line_cnt_s = 11'd1;
        end else if (line_cnt_r != CNT11_MAX_C) begin
            line_cnt_s = line_cnt_r + 11'd1;
        end else begin
            line_cnt_s = line_cnt_r;
        end

        if (!vif.hsync_in) begin
            hwid_cnt_s = 11'd0;
        end else if (hwid_cnt_r != CNT11_MAX_C) begin
            hwid_cnt_s = hwid_cnt_r + 11'd1;
        end else begin
            hwid_cnt_s = hwid_cnt_r;
        end

        // The line counter only passes the timeout value once before saturating.
        timeout_s = ~hrise_s & (line_cnt_r == LINE_TMO_C);
        h_err_s   = (hrise_s & h_seen_r & (line_cnt_r != LINE_LEN_C))
                  | (hfall_s & (hwid_cnt_r != HSYNC_LEN_C))
                  | timeout_s;

        if (timeout_s) begin
            h_seen_s = 1'b0;
        end else if (hrise_s) begin
            h_seen_s = 1'b1;
        end else begin
            h_seen_s = h_seen_r;
        end

        if (vrise_s) begin
            frame_lines_s = 10'd0;
        end else if (hrise_s && (frame_lines_r != CNT10_MAX_C)) begin
            frame_lines_s = frame_lines_r + 10'd1;
        end else begin
            frame_lines_s = frame_lines_r;
        end

        if (!vif.vsync_in) begin
            vwid_cnt_s = 10'd0;
        end else if (hrise_s && (vwid_cnt_r != CNT10_MAX_C)) begin
            vwid_cnt_s = vwid_cnt_r + 10'd1;
        end else begin
            vwid_cnt_s = vwid_cnt_r;
        end

        v_err_s   = (vrise_s & (state_r != SEARCH) & (frame_lines_r != FRAME_LEN_C))
                  | (vfall_s & (vwid_cnt_r != VSYNC_LEN_C));
        err_any_s = h_err_s | v_err_s;

        if (err_any_s && (err_count_r != 8'hFF)) begin
            err_count_s = err_count_r + 8'd1;
        end else begin
            err_count_s = err_count_r;
        end

        state_s       = state_r;
        good_frames_s = good_frames_r;
        case (state_r)
            SEARCH: begin
                if (vrise_s) begin
                    state_s       = TRACK;
                    good_frames_s = 4'd0;
                end else begin
                    state_s = SEARCH;
                end
            end
            TRACK: begin
                if (err_any_s) begin
                    state_s       = SEARCH;
                    good_frames_s = 4'd0;
                end else if (vrise_s) begin
                    good_frames_s = good_frames_r + 4'd1;
                    if ((good_frames_r + 4'd1) == LOCK_C) begin
                        state_s = LOCKED;
                    end else begin
                        state_s = TRACK;
                    end
                end else begin
                    state_s = TRACK;
                end
            end
            LOCKED: begin
                if (err_any_s) begin
                    state_s       = SEARCH;
                    good_frames_s = 4'd0;
                end else begin
                    state_s = LOCKED;
                end
            end
            default: begin
                state_s       = SEARCH;
                good_frames_s = 4'd0;
            end
        endcase

        // hpos is re-anchored to the sync start on every hsync rise.
        hwrap_s = ~hrise_s & (hpos_r == HPOS_LAST_C);
        if (hrise_s) begin
            hpos_s = HPOS_SYNC_C;
        end else if (hwrap_s) begin
            hpos_s = 10'd0;
        end else begin
            hpos_s = hpos_r + 10'd1;
        end

        if (vrise_s) begin
            vpos_s = VPOS_SYNC_C;
        end else if (hwrap_s) begin
            if (vpos_r == VPOS_LAST_C) begin
                vpos_s = 10'd0;
            end else begin
                vpos_s = vpos_r + 10'd1;
            end
        end else begin
            vpos_s = vpos_r;
        end

        de_s          = (state_s == LOCKED) & (hpos_s < H_VIS_C) & (vpos_s < V_VIS_C);
        frame_start_s = vrise_s & (state_r == LOCKED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= SEARCH;
            good_frames_r <= 4'd0;
            hsync_d_r     <= 1'b0;
            vsync_d_r     <= 1'b0;
            h_seen_r      <= 1'b0;
            line_cnt_r    <= 11'd0;
            hwid_cnt_r    <= 11'd0;
            frame_lines_r <= 10'd0;
            vwid_cnt_r    <= 10'd0;
            hpos_r        <= 10'd0;
            vpos_r        <= 10'd0;
            locked_r      <= 1'b0;
            de_r          <= 1'b0;
            frame_start_r <= 1'b0;
            h_err_r       <= 1'b0;
            v_err_r       <= 1'b0;
            err_count_r   <= 8'd0;
        end else begin
            state_r       <= state_s;
            good_frames_r <= good_frames_s;
            hsync_d_r     <= vif.hsync_in;
            vsync_d_r     <= vif.vsync_in;
            h_seen_r      <= h_seen_s;
            line_cnt_r    <= line_cnt_s;
            hwid_cnt_r    <= hwid_cnt_s;
            frame_lines_r <= frame_lines_s;
            vwid_cnt_r    <= vwid_cnt_s;
            hpos_r        <= hpos_s;
            vpos_r        <= vpos_s;
            locked_r      <= (state_s == LOCKED);
            de_r          <= de_s;
            frame_start_r <= frame_start_s;
            h_err_r       <= h_err_s;
            v_err_r       <= v_err_s;
            err_count_r   <= err_count_s;
        end
    end

    assign vif.locked      = locked_r;
    assign vif.hpos_rx     = hpos_r;
    assign vif.vpos_rx     = vpos_r;
    assign vif.de_rx       = de_r;
    assign vif.frame_start = frame_start_r;
    assign vif.h_err       = h_err_r;
    assign vif.v_err       = v_err_r;
    assign vif.err_count   = err_count_r;
endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor in a reduced video mode: sync streams with
// randomly placed faults, predicted by a timestamp-based model and scoreboarded.
module tb_vga_timing_monitor;
    localparam int HA = 16, HF = 4, HS = 8, HB = 4;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int LOCKF = 2;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VT  = VA + VF + VS + VB;
    localparam int HSS = HA + HF;
    localparam int VSS = VA + VF;

    localparam int ST_SEARCH = 0, ST_TRACK = 1, ST_LOCKED = 2;
    localparam int F_NONE = 0, F_LONG = 1, F_VSW = 2, F_HSW = 3, F_HOLD = 4, F_RST = 5;

    typedef struct {
        int due;
        int locked;
        int hpos;
        int vpos;
        int de;
        int fs;
        int he;
        int ve;
        int errc;
    } exp_t;

    logic clk;
    logic reset;
    vga_timing_monitor_if vif();

    vga_timing_monitor #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .LOCK_FRAMES(LOCKF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vif(vif)
    );

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    // Model state: times of last hsync rise / last low hsync, counts of
    // sync rises, lock state and the position origin.
    int m_ph, m_pv, m_base_l, m_base_hw, m_hseen, m_nl, m_nvs;
    int m_st, m_gf, m_errc, m_hp_off, m_vp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int pmod(input int a, input int m);
        return ((a % m) + m) % m;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Apply one cycle of input and queue the outputs expected after the next edge.
    task automatic drive(input bit h_in, input bit v_in, input bit rst);
        exp_t e;
        int   t, lcnt, hw, hp_now, hp_nx, vp_nx, st_old;
        bit   hr, hf, vr, vf, he, ve, err;
        @(posedge clk);
        #1;
        reset        = rst;
        vif.hsync_in = h_in;
        vif.vsync_in = v_in;
        t     = cyc;
        e.due = t + 1;
        if (rst) begin
            m_ph = 0; m_pv = 0; m_hseen = 0; m_nl = 0; m_nvs = 0;
            m_base_l = t + 1; m_base_hw = t + 1;
            m_st = ST_SEARCH; m_gf = 0; m_errc = 0;
            m_hp_off = -(t + 1); m_vp = 0;
            e.locked = 0; e.hpos = 0; e.vpos = 0; e.de = 0; e.fs = 0;
            e.he = 0; e.ve = 0; e.errc = 0;
        end else begin
            hr = h_in && !m_ph;
            hf = !h_in && m_ph;
            vr = v_in && !m_pv;
            vf = !v_in && m_pv;
            lcnt   = imin(t - m_base_l, 2047);
            hw     = imin(t - m_base_hw, 2047);
            hp_now = pmod(m_hp_off + t, HT);
            he  = (hr && m_hseen && lcnt != HT) || (hf && hw != HS) || (!hr && lcnt == 2 * HT);
            ve  = (vr && m_st != ST_SEARCH && m_nl != VT) || (vf && m_nvs != VS);
            err = he || ve;
            if (!hr && lcnt == 2 * HT) m_hseen = 0;
            else if (hr) m_hseen = 1;
            if (hr) begin
                m_base_l = t;
                m_hp_off = HSS - (t + 1);
            end
            if (!h_in) m_base_hw = t + 1;
            hp_nx = pmod(m_hp_off + t + 1, HT);
            if (vr) vp_nx = VSS;
            else if (!hr && hp_now == HT - 1) vp_nx = (m_vp + 1) % VT;
            else vp_nx = m_vp;
            m_vp = vp_nx;
            if (vr) m_nl = 0;
            else if (hr) m_nl = imin(m_nl + 1, 1023);
            if (!v_in) m_nvs = 0;
            else if (hr) m_nvs = imin(m_nvs + 1, 1023);
            st_old = m_st;
            if (m_st == ST_SEARCH) begin
                if (vr) begin m_st = ST_TRACK; m_gf = 0; end
            end else if (m_st == ST_TRACK) begin
                if (err) begin m_st = ST_SEARCH; m_gf = 0; end
                else if (vr) begin
                    m_gf++;
                    if (m_gf == LOCKF) m_st = ST_LOCKED;
                end
            end else begin
                if (err) begin m_st = ST_SEARCH; m_gf = 0; end
            end
            if (err) m_errc = imin(m_errc + 1, 255);
            e.locked = (m_st == ST_LOCKED);
            e.hpos   = hp_nx;
            e.vpos   = vp_nx;
            e.de     = (e.locked != 0 && hp_nx < HA && vp_nx < VA);
            e.fs     = (vr && st_old == ST_LOCKED);
            e.he     = he;
            e.ve     = ve;
            e.errc   = m_errc;
            m_ph = h_in;
            m_pv = v_in;
        end
        q.push_back(e);
    endtask

    // One frame of the reduced mode, optionally carrying one fault.
    task automatic run_frame(input int kind, input int fline);
        int len, hsw, vsw;
        bit hs_on, h, v, r;
        for (int ln = 0; ln < VT; ln++) begin
            len   = (kind == F_LONG && ln == fline) ? HT + 1 : HT;
            hsw   = (kind == F_HSW && ln == fline) ? HS - 1 : HS;
            vsw   = (kind == F_VSW) ? VS + 1 : VS;
            hs_on = !(kind == F_HOLD && ln >= fline && ln < fline + 4);
            v     = (ln >= VSS && ln < VSS + vsw);
            for (int c = 0; c < len; c++) begin
                h = hs_on && c >= HSS && c < HSS + hsw;
                r = (kind == F_RST && ln == fline && c == 2);
                drive(h, v, r);
            end
        end
    endtask

    // Scoreboard monitor: pops the expectation due this edge and compares.
    initial begin
        exp_t e;
        int   de_cnt;
        bit   full;
        de_cnt = 0;
        full   = 1'b0;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].due < cyc) begin
                e = q.pop_front();
                check("sample_due", cyc, e.due);
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                check("locked", int'(vif.locked), e.locked);
                check("hpos_rx", int'(vif.hpos_rx), e.hpos);
                check("vpos_rx", int'(vif.vpos_rx), e.vpos);
                check("de_rx", int'(vif.de_rx), e.de);
                check("frame_start", int'(vif.frame_start), e.fs);
                check("h_err", int'(vif.h_err), e.he);
                check("v_err", int'(vif.v_err), e.ve);
                check("err_count", int'(vif.err_count), e.errc);
            end
            if (vif.de_rx === 1'b1) de_cnt++;
            if (vif.locked !== 1'b1) full = 1'b0;
            if (vif.frame_start === 1'b1) begin
                if (full) check("de_per_frame", de_cnt, HA * VA);
                de_cnt = 0;
                full   = 1'b1;
            end
        end
    end

    initial begin
        int nburst;
        reset        = 1'b1;
        vif.hsync_in = 1'b0;
        vif.vsync_in = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1);
        repeat (5) run_frame(F_NONE, 0);
        run_frame(F_LONG, int'($urandom_range(VT - 1, 0)));
        repeat (4) run_frame(F_NONE, 0);
        run_frame(F_VSW, 0);
        repeat (4) run_frame(F_NONE, 0);
        run_frame(F_HSW, int'($urandom_range(VT - 1, 0)));
        repeat (4) run_frame(F_NONE, 0);
        run_frame(F_HOLD, int'($urandom_range(VA - 5, 1)));
        repeat (4) run_frame(F_NONE, 0);
        nburst = 300 + int'($urandom_range(40, 0));
        for (int i = 0; i < nburst; i++) drive(i[0] == 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("err_count_saturated", int'(vif.err_count), 255);
        repeat (4) run_frame(F_NONE, 0);
        run_frame(F_RST, int'($urandom_range(VSS - 2, 1)));
        repeat (4) run_frame(F_NONE, 0);
        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
Receive-side counterpart of the VGA sync generator. Samples active-high hsync/vsync, measures line length, sync widths and lines per frame against the configured mode, and declares lock after consecutive good frames. When locked it regenerates pixel/line position and a data-enable for downstream capture and self-check logic.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
LOCK_FRAMES, 2, consecutive good frames required for lock (1..15)
- Derived: H_TOTAL = sum of H_*, default 800. V_TOTAL = sum of V_*, default 525. H_SYNC_START = H_ACTIVE + H_FRONT, default 656. V_SYNC_START = V_ACTIVE + V_FRONT, default 490.

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high
hsync_in  in  1  horizontal sync, active-high, clk domain
vsync_in  in  1  vertical sync, active-high, clk domain
locked  out  1  timing matches mode
hpos_rx  out  10  recovered pixel index
vpos_rx  out  10  recovered line index
de_rx  out  1  locked and in visible area
frame_start  out  1  1-cycle pulse on vsync rise while locked
h_err  out  1  1-cycle pulse, horizontal timing fault
v_err  out  1  1-cycle pulse, vertical timing fault
err_count  out  8  saturating count of error cycles

Behaviour:
- Edge detect: hsync_d/vsync_d are registered copies of the inputs. hrise = hsync_in & ~hsync_d, hfall = ~hsync_in & hsync_d; vrise and vfall likewise.
- Reset: all outputs 0. hsync_d, vsync_d, counters and good_frames are 0. State = SEARCH. h_seen = 0.
- Line counter (11 bit):
  - Cleared to 1 on hrise; otherwise increments, saturating at 2047.
  - On hrise with h_seen = 1: h_err if counter != H_TOTAL. Then set h_seen = 1.
- Hsync width counter: counts cycles with hsync_in high. On hfall, h_err if count != H_SYNC.
- Timeout: line counter reaching 2*H_TOTAL with no hrise gives h_err (once), clears h_seen, and forces SEARCH.
- Frame line counter (10 bit): counts hrise events and is cleared on vrise. On vrise in TRACK or LOCKED, v_err if count != V_TOTAL.
- Vsync width counter: counts hrise events while vsync_in is high. On vfall, v_err if count != V_SYNC.
- Error handling:
  - h_err and v_err may pulse in the same cycle.
  - err_count increments by exactly 1 in any cycle where either pulses, saturating at 255.
  - err_count is cleared only by reset.
- State machine (2-bit), evaluated on the error outcome of the same cycle:
  - SEARCH: on vrise go to TRACK, good_frames = 0. Errors in SEARCH pulse and count but do not change state.
  - TRACK: any error goes to SEARCH with good_frames = 0. An error-free vrise increments good_frames; when the new value equals LOCK_FRAMES, go to LOCKED.
  - LOCKED: any error goes to SEARCH.
  - locked = (state == LOCKED), registered, so it changes the cycle after the transition edge.
- Position recovery (runs in all states; outputs only qualified by locked):
  - The cycle after hrise, hpos_rx = H_SYNC_START. Otherwise hpos_rx increments and wraps H_TOTAL-1 to 0.
  - On vrise, vpos_rx loads V_SYNC_START (priority over increment). Otherwise vpos_rx increments when hpos_rx wraps, and wraps V_TOTAL-1 to 0.
- Output qualification:
  - de_rx = locked & (hpos_rx < H_ACTIVE) & (vpos_rx < V_ACTIVE), registered consistently with hpos_rx/vpos_rx.
  - frame_start pulses the cycle after vrise when state is LOCKED before that edge.
- Reset mid-frame returns to the reset state in one cycle. The next vrise starts TRACK.

Test Plan:
- Nominal 800x525 stream (hsync 96 px at 656, vsync 2 lines at line 490) from reset → locked rises the cycle after the 3rd vrise. h_err = v_err = 0. err_count = 0.
- Locked nominal stream → hpos_rx = 656 the cycle after each hrise. hpos_rx wraps 799 to 0. de_rx high for exactly 640x480 cycles per frame. frame_start is 1 cycle per frame.
- While locked, one line of 801 cycles → single h_err pulse. locked falls the next cycle. err_count = 1. Relock after 3 further vrises.
- While locked, vsync 3 lines wide → v_err on vfall. State goes to SEARCH. Hsync width 95 → h_err on hfall.
- Hsync held low while locked → h_err exactly at line counter 1600, locked drops, no further h_err until hsync returns. Inject 300 error cycles → err_count holds 255.
- Assert reset mid-frame while locked → next cycle all outputs 0. With reset released and the stream continuing, locked returns after 3 vrises.
